// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - 6-byte UART command-frame assembler with XOR checksum and inter-byte timeout
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   rx_ready, rx_data   one-cycle byte strobe and byte from the UART receiver
//   cmd_valid, cmd_ack  command handshake; cmd_valid held until cmd_valid & cmd_ack
//   cmd_op, cmd_addr    opcode and register address of the held command
//   cmd_data            {data_hi, data_lo} of the held command
//   busy                high whenever the FSM is not in IDLE
//   err_csum            one-cycle pulse: checksum byte did not match
//   err_timeout         one-cycle pulse: inter-byte gap exceeded TIMEOUT_CYCLES
//   err_overrun         one-cycle pulse: byte arrived while a command was held
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         TO_W           = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  input  logic        cmd_ack,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        busy,
  output logic        err_csum,
  output logic        err_timeout,
  output logic        err_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    GET_OP,
    GET_ADDR,
    GET_DHI,
    GET_DLO,
    GET_CSUM,
    HOLD
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [7:0]      op_q;
  logic [7:0]      addr_q;
  logic [7:0]      dhi_q;
  logic [7:0]      dlo_q;
  logic [7:0]      csum;
  logic [TO_W-1:0] to_cnt;
  logic            in_frame;

  assign in_frame = (state inside {GET_OP, GET_ADDR, GET_DHI, GET_DLO, GET_CSUM});

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_op      <= 8'h00;
      cmd_addr    <= 8'h00;
      cmd_data    <= 16'h0000;
      err_csum    <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      op_q        <= 8'h00;
      addr_q      <= 8'h00;
      dhi_q       <= 8'h00;
      dlo_q       <= 8'h00;
      csum        <= 8'h00;
      to_cnt      <= '0;
    end else begin
      err_csum    <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;

      if (in_frame) begin
        if (rx_ready) begin
          // A byte landing on the terminal count still counts: checked before the timeout.
          to_cnt <= '0;
          case (state)
            GET_OP: begin
              op_q  <= rx_data;
              csum  <= csum ^ rx_data;
              state <= GET_ADDR;
            end
            GET_ADDR: begin
              addr_q <= rx_data;
              csum   <= csum ^ rx_data;
              state  <= GET_DHI;
            end
            GET_DHI: begin
              dhi_q <= rx_data;
              csum  <= csum ^ rx_data;
              state <= GET_DLO;
            end
            GET_DLO: begin
              dlo_q <= rx_data;
              csum  <= csum ^ rx_data;
              state <= GET_CSUM;
            end
            default: begin
              if (rx_data == csum) begin
                cmd_op    <= op_q;
                cmd_addr  <= addr_q;
                cmd_data  <= {dhi_q, dlo_q};
                cmd_valid <= 1'b1;
                state     <= HOLD;
              end else begin
                err_csum <= 1'b1;
                state    <= IDLE;
                busy     <= 1'b0;
              end
            end
          endcase
        end else if (to_cnt == TO_LAST) begin
          err_timeout <= 1'b1;
          to_cnt      <= '0;
          state       <= IDLE;
          busy        <= 1'b0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (rx_ready && rx_data == SYNC_BYTE) begin
              csum  <= 8'h00;
              state <= GET_OP;
              busy  <= 1'b1;
            end
          end
          HOLD: begin
            // The held command is never disturbed; incoming bytes are dropped and flagged.
            if (rx_ready) begin
              err_overrun <= 1'b1;
            end
            if (cmd_valid && cmd_ack) begin
              cmd_valid <= 1'b0;
              state     <= IDLE;
              busy      <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - scoreboard bench for uart_cmd_ctrl with frame-level reference model
module tb_uart_cmd_ctrl;

  localparam int         T    = 50;
  localparam logic [7:0] SYNC = 8'hA5;

  localparam int K_CMD  = 0;
  localparam int K_CSUM = 1;
  localparam int K_TO   = 2;
  localparam int K_OVR  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        cmd_ack = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        busy;
  logic        err_csum;
  logic        err_timeout;
  logic        err_overrun;

  uart_cmd_ctrl #(
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (T),
    .TO_W           (17)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .cmd_valid   (cmd_valid),
    .cmd_ack     (cmd_ack),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .busy        (busy),
    .err_csum    (err_csum),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  int   cyc   = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: frame-level view of the byte stream, timestamped by clock edge.
  typedef struct {
    int          kind;
    int          at;
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] frame_q[$];
  bit         holding = 1'b0;
  int         last_c  = 0;

  function automatic void push_ev(input int k, input int at, input logic [7:0] o,
                                  input logic [7:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = k; e.at = at; e.op = o; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction

  // A partial frame dies T edges after its last byte if nothing arrived in between.
  function automatic void model_advance(input int t);
    if (frame_q.size() > 0 && t >= last_c + T) begin
      push_ev(K_TO, last_c + T, 8'h00, 8'h00, 16'h0000);
      frame_q.delete();
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int c);
    logic [7:0] x;
    model_advance(c - 1);
    if (holding) begin
      push_ev(K_OVR, c, 8'h00, 8'h00, 16'h0000);
    end else if (frame_q.size() == 0) begin
      if (b == SYNC) frame_q.push_back(b);
    end else begin
      frame_q.push_back(b);
      if (frame_q.size() == 6) begin
        x = frame_q[1] ^ frame_q[2] ^ frame_q[3] ^ frame_q[4];
        if (x == frame_q[5]) begin
          push_ev(K_CMD, c, frame_q[1], frame_q[2], {frame_q[3], frame_q[4]});
          holding = 1'b1;
        end else begin
          push_ev(K_CSUM, c, 8'h00, 8'h00, 16'h0000);
        end
        frame_q.delete();
      end
    end
    last_c = c;
  endfunction

  task automatic check_state();
    bit exp_busy;
    exp_busy = (frame_q.size() > 0) || holding;
    check(busy == exp_busy, "busy", {31'd0, busy}, {31'd0, exp_busy});
    check(cmd_valid == holding, "cmd_valid_level", {31'd0, cmd_valid}, {31'd0, holding});
  endtask

  // All stimulus tasks start and end at posedge + #1.
  task automatic send(input logic [7:0] b, input bit ack);
    rx_ready = 1'b1;
    rx_data  = b;
    cmd_ack  = ack;
    model_byte(b, cyc + 1);
    if (ack) holding = 1'b0;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    cmd_ack  = 1'b0;
    check_state();
  endtask

  task automatic idle(input int k);
    model_advance(cyc + k);
    repeat (k) begin
      @(posedge clk); #1;
    end
    check_state();
  endtask

  task automatic do_ack();
    cmd_ack = 1'b1;
    holding = 1'b0;
    @(posedge clk); #1;
    cmd_ack = 1'b0;
    check_state();
  endtask

  task automatic send_frame(input logic [7:0] o, input logic [7:0] a, input logic [7:0] dh,
                            input logic [7:0] dl, input bit bad);
    logic [7:0] cs;
    cs = o ^ a ^ dh ^ dl;
    if (bad) cs = cs ^ 8'($urandom_range(1, 255));
    send(SYNC, 1'b0);
    send(o, 1'b0);
    send(a, 1'b0);
    send(dh, 1'b0);
    send(dl, 1'b0);
    send(cs, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    frame_q.delete();
    holding = 1'b0;
    check({cmd_valid, busy, err_csum, err_timeout, err_overrun, cmd_op, cmd_addr, cmd_data} == 37'd0,
          "reset_outputs", {cmd_valid, busy, err_csum, err_timeout, err_overrun, 3'd0, cmd_op, cmd_addr, 8'd0},
          32'd0);
    check_state();
  endtask

  // Monitor: pops expected events whenever the DUT pulses an error or raises cmd_valid.
  logic        prev_valid = 1'b0;
  logic [7:0]  last_op    = 8'h00;
  logic [7:0]  last_addr  = 8'h00;
  logic [15:0] last_data  = 16'h0000;

  task automatic handle_ev(input int k);
    ev_t e;
    if (exp_q.size() == 0) begin
      check(1'b0, "unexpected_event", k, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check(e.kind == k, "event_kind", k, e.kind);
      check(e.at == cyc, "event_cycle", cyc, e.at);
      if (k == K_CMD) begin
        check({cmd_op, cmd_addr, cmd_data} == {e.op, e.addr, e.data}, "cmd_fields",
              {cmd_op, cmd_addr, cmd_data}, {e.op, e.addr, e.data});
        last_op   = e.op;
        last_addr = e.addr;
        last_data = e.data;
      end
    end
  endtask

  initial begin : monitor
    int nb;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
          check(1'b0, "missing_event", exp_q[0].kind, exp_q[0].at);
          void'(exp_q.pop_front());
        end
        if (rst_q) begin
          check({cmd_valid, busy, err_csum, err_timeout, err_overrun, cmd_op, cmd_addr, cmd_data} == 37'd0,
                "reset_state", {cmd_valid, busy, err_csum, err_timeout, err_overrun, 3'd0, cmd_op, cmd_addr, 8'd0},
                32'd0);
          prev_valid = 1'b0;
          last_op    = 8'h00;
          last_addr  = 8'h00;
          last_data  = 16'h0000;
        end else begin
          nb = int'(err_csum) + int'(err_timeout) + int'(err_overrun);
          if (nb > 1) check(1'b0, "err_onehot", nb, 1);
          if (cmd_valid && !prev_valid) begin
            handle_ev(K_CMD);
          end else begin
            check({cmd_op, cmd_addr, cmd_data} == {last_op, last_addr, last_data}, "cmd_stable",
                  {cmd_op, cmd_addr, cmd_data}, {last_op, last_addr, last_data});
          end
          if (err_csum)    handle_ev(K_CSUM);
          if (err_timeout) handle_ev(K_TO);
          if (err_overrun) handle_ev(K_OVR);
          prev_valid = cmd_valid;
        end
      end
    end
  end

  initial begin : stimulus
    int a;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_state();

    // Good frame, ack after 5 cycles.
    send_frame(8'h10, 8'h03, 8'h12, 8'h34, 1'b0);
    idle(5);
    do_ack();

    // Bad checksum, then a good frame.
    send(SYNC, 0); send(8'h10, 0); send(8'h03, 0); send(8'h12, 0); send(8'h34, 0); send(8'h00, 0);
    idle(2);
    send_frame(8'h21, 8'h44, 8'hBE, 8'hEF, 1'b0);
    idle(1);
    do_ack();

    // Garbage before a frame.
    send(8'h00, 0); send(8'hFF, 0);
    send_frame(8'h5A, 8'h07, 8'hA5, 8'h00, 1'b0);
    do_ack();

    // Timeout after two bytes, then recovery.
    send(SYNC, 0); send(8'h10, 0);
    idle(60);
    send_frame(8'h33, 8'h01, 8'h02, 8'h03, 1'b0);
    do_ack();

    // Gap exactly at the terminal count: the byte wins.
    send(SYNC, 0);
    idle(T - 1);
    send(8'h66, 0); send(8'h11, 0);
    idle(T - 1);
    send(8'h22, 0); send(8'h33, 0); send(8'h66 ^ 8'h11 ^ 8'h22 ^ 8'h33, 0);
    do_ack();

    // Gap one past the terminal count: timeout.
    send(SYNC, 0);
    idle(T);
    send(8'h10, 0);

    // Overrun while holding, including a byte in the ack cycle.
    send_frame(8'h90, 8'hC0, 8'h12, 8'h34, 1'b0);
    idle(3);
    send(8'h77, 0);
    idle(2);
    send(8'h55, 1);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    do_ack();

    // Reset mid-frame and in HOLD.
    send(SYNC, 0); send(8'h10, 0); send(8'h03, 0);
    do_reset();
    send_frame(8'h10, 8'h03, 8'h12, 8'h34, 1'b0);
    idle(2);
    do_reset();
    send_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b0);
    do_ack();

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      a = int'($urandom_range(0, 6));
      case (a)
        0, 1: send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        2:    send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        3:    send(($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom), 1'b0);
        4:    idle(int'($urandom_range(0, 60)));
        5: begin
          if (holding) begin
            if ($urandom_range(0, 1) == 1) do_ack();
            else send(8'($urandom), 1'b1);
          end
        end
        default: idle(($urandom_range(0, 1) == 1) ? T - 1 : T);
      endcase
    end

    if (holding) do_ack();
    idle(T + 5);
    @(negedge clk); #1;
    check(exp_q.size() == 0, "leftover_events", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
